// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers; holds each frame until busy completes.
// Optional `UART_ARB_PRIO0_EN: requester 0 always wins and does not move the round-robin pointer.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [NUM_REQ*8-1:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]     REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]     REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]     REQ_READY,
  output logic [7:0]             TX_P_DATA,
  output logic                   TX_DATA_VALID,
  output logic                   TX_PAR_EN,
  output logic                   TX_PAR_TYP,
  input  logic                   TX_BUSY,
  output logic [2:0]             GRANT_ID,
  output logic                   ACTIVE,
  output logic                   ERR_TIMEOUT
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] data_q, data_d;
  logic       par_en_q, par_en_d;
  logic       par_typ_q, par_typ_d;
  logic [7:0] cnt_q, cnt_d;
  logic       active_q;

  logic [7:0]  valid_pad, pen_pad, ptyp_pad;
  logic [63:0] data_pad;
  logic        found;
  logic [2:0]  winner;
  logic [3:0]  cand;
  logic        grant_fire, tx_valid, err_fire;

  // Pad requester vectors to 8 entries so a 3-bit index is always in range.
  always_comb begin
    valid_pad = '0;
    pen_pad   = '0;
    ptyp_pad  = '0;
    data_pad  = '0;
    valid_pad[NUM_REQ-1:0]  = REQ_VALID;
    pen_pad[NUM_REQ-1:0]    = REQ_PAR_EN;
    ptyp_pad[NUM_REQ-1:0]   = REQ_PAR_TYP;
    data_pad[NUM_REQ*8-1:0] = REQ_DATA;
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
`ifdef UART_ARB_PRIO0_EN
    if (valid_pad[0]) begin
      found  = 1'b1;
      winner = 3'd0;
    end
`endif
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
`ifdef UART_ARB_PRIO0_EN
      if (!found && (cand != 4'd0) && valid_pad[cand[2:0]]) begin
`else
      if (!found && valid_pad[cand[2:0]]) begin
`endif
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    cnt_d      = cnt_q;
    grant_fire = 1'b0;
    tx_valid   = 1'b0;
    err_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !TX_BUSY) begin
          grant_fire = 1'b1;
          data_d     = data_pad[{winner, 3'b000} +: 8];
          par_en_d   = pen_pad[winner];
          par_typ_d  = ptyp_pad[winner];
          grant_d    = winner;
`ifdef UART_ARB_PRIO0_EN
          if (winner != 3'd0) last_d = winner;
`else
          last_d     = winner;
`endif
          state_d    = LOAD;
        end
      end
      LOAD: begin
        tx_valid = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // Frame is dropped on timeout; no retry.
          if (cnt_q == 8'(TIMEOUT - 1)) begin
            err_fire = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      last_q    <= 3'(NUM_REQ - 1);
      grant_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      cnt_q     <= cnt_d;
      active_q  <= (state_d != IDLE);
    end
  end

  // Pulses are masked while reset is applied so nothing is accepted during reset.
  always_comb begin
    REQ_READY = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      REQ_READY[j] = RST && grant_fire && (winner == 3'(j));
    end
  end

  assign TX_DATA_VALID = RST && tx_valid;
  assign ERR_TIMEOUT   = RST && err_fire;
  assign TX_P_DATA     = data_q;
  assign TX_PAR_EN     = par_en_q;
  assign TX_PAR_TYP    = par_typ_q;
  assign GRANT_ID      = grant_q;
  assign ACTIVE        = active_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `UART_TX` instance between `NUM_REQ` byte producers. It accepts one byte plus per-byte parity settings from the winning requester and drives the transmitter's `P_DATA`/`Data_Valid`/`PAR_EN`/`PAR_TYP` inputs. It then tracks the transmitter's `busy` output through the full frame before granting again. It sits directly in front of `UART_TX`, which is clocked on the same `CLK`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 8: max cycles to wait for `TX_BUSY` to rise after `TX_DATA_VALID`, 2..255.

- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-low reset.
- `REQ_VALID` in NUM_REQ: requester i has a byte pending.
- `REQ_DATA` in NUM_REQ*8: byte of requester i at bits [8i+7:8i].
- `REQ_PAR_EN` in NUM_REQ: parity enable for requester i.
- `REQ_PAR_TYP` in NUM_REQ: parity type for requester i (0 even, 1 odd).
- `REQ_READY` out NUM_REQ: one-hot, 1-cycle accept pulse; byte transferred when `REQ_VALID[i] & REQ_READY[i]`.
- `TX_P_DATA` out 8: to `UART_TX.P_DATA`.
- `TX_DATA_VALID` out 1: to `UART_TX.Data_Valid`.
- `TX_PAR_EN` out 1: to `UART_TX.PAR_EN`.
- `TX_PAR_TYP` out 1: to `UART_TX.PAR_TYP`.
- `TX_BUSY` in 1: from `UART_TX.busy`.
- `GRANT_ID` out 3: index of current or last granted requester.
- `ACTIVE` out 1: high in every state except IDLE.
- `ERR_TIMEOUT` out 1: 1-cycle pulse when `TX_BUSY` fails to rise.

## Operation
- FSM states are IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
- **IDLE:** when any `REQ_VALID` is high and `TX_BUSY` is 0:
  - Pick the winner by round-robin, searching from `last+1` modulo `NUM_REQ`.
  - Pulse `REQ_READY[winner]`.
  - Latch the winner's data, par_en and par_typ into the holding registers.
  - Set `last` and `GRANT_ID` to the winner.
  - Go to LOAD.
  - If `TX_BUSY` is 1 in IDLE, grant nothing and stay in IDLE.
- **LOAD:** `TX_DATA_VALID`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `TX_BUSY` is 1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, pulse `ERR_TIMEOUT` and go to IDLE. The frame is dropped and there is no retry.
- **WAIT_DONE:** when `TX_BUSY` is 0, go to IDLE.
- **Holding registers:** `TX_P_DATA`, `TX_PAR_EN` and `TX_PAR_TYP` come straight from the holding registers. They stay stable from LOAD until the next grant.
- **Simultaneous requests:** exactly one grant per frame. A requester that drops `REQ_VALID` before its grant loses nothing, because it was never accepted.
- **`REQ_READY` gating:** never asserted outside IDLE, and never to a requester whose `REQ_VALID` is 0.
- **Reset:** an active reset at any state, including mid-frame, forces:
  - state IDLE;
  - `last`=NUM_REQ-1, so requester 0 wins first;
  - holding registers, `TX_*` outputs, `REQ_READY`, `GRANT_ID`, `ACTIVE`, `ERR_TIMEOUT` and the counter all 0.
  - The transmitter has its own reset and is not sequenced by this block.

## Timing
- Grant to `TX_DATA_VALID`: 1 cycle (`REQ_READY` in cycle t, `TX_DATA_VALID` in t+1).
- `TX_BUSY` is expected to rise at t+2. The timeout fires at cycle t+1+TIMEOUT if it has not.
- End of frame to next grant:
  - `TX_BUSY` falls in cycle u, so WAIT_DONE sees 0 in cycle u.
  - IDLE is entered at u+1, and the earliest next `REQ_READY` is at u+1.
- Back-to-back throughput: one frame per (UART frame length + 3) cycles.
- `ACTIVE` is registered and follows the state: it is 1 from the cycle after the grant until the cycle after `TX_BUSY` falls.
- The counter is 8 bits and saturates. Comparison is `counter == TIMEOUT-1` on the increment cycle.

## Configuration
- **`UART_ARB_PRIO0_EN` defined:** requester 0 is high priority. In IDLE, if `REQ_VALID[0]` is set, requester 0 wins regardless of `last`. All others arbitrate round-robin among themselves. A requester-0 grant does not update `last`.
- **`UART_ARB_PRIO0_EN` undefined:** pure round-robin over all `NUM_REQ` requesters.

## Test plan
- **Reset and idle:**
  - Stimulus: `RST`=0 for 3 cycles with `REQ_VALID`=4'b1111.
  - Response: all outputs 0, no `REQ_READY`. On release, the first grant goes to requester 0 with `GRANT_ID`=0.
- **Single byte:**
  - Stimulus: requester 2 sends 8'hA5 with `PAR_EN`=1, `PAR_TYP`=1; the `UART_TX` model holds busy for 11 cycles.
  - Response: `REQ_READY`=4'b0100 for 1 cycle. `TX_DATA_VALID` pulses 1 cycle later with `TX_P_DATA`=8'hA5, `TX_PAR_EN`=1, `TX_PAR_TYP`=1, held until the next grant. `ACTIVE` drops 1 cycle after busy falls.
- **Fairness:**
  - Stimulus: all 4 requesters stay valid for 8 frames.
  - Response: grant order 0,1,2,3,0,1,2,3. With `UART_ARB_PRIO0_EN` defined: 0 on every frame while `REQ_VALID[0]` is held.
- **Busy blocking:**
  - Stimulus: `TX_BUSY` forced to 1 while in IDLE, with a valid request.
  - Response: no `REQ_READY` until `TX_BUSY`=0. Grant follows in the same cycle.
- **Timeout:**
  - Stimulus: the model never raises busy, `TIMEOUT`=8.
  - Response: `ERR_TIMEOUT` pulses exactly 9 cycles after the grant. Back in IDLE, the next requester is granted.
- **Mid-frame reset:**
  - Stimulus: `RST`=0 during WAIT_DONE.
  - Response: IDLE next cycle with all outputs 0. After release, requester 0 is granted first.
